// File: rtl/mycpu_head_pkg.sv
// Shared definitions for the CPU-side SRAM responder: address map defaults and FSM encodings.
package mycpu_head;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h1C000000;
  localparam int          AW_DEFAULT        = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } resp_state_t;

endpackage

// File: rtl/sram_bank.sv
// Single-write-port word array with byte enables and a registered, read-first data output.
module sram_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic [3:0]    wbe,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic          rd_clr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 2**AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Sampling mem with the same edge as the write returns the pre-write word.
  always_ff @(posedge clk) begin
    if (reset)       rdata <= '0;
    else if (rd_clr) rdata <= '0;
    else if (rd_en)  rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_sram_responder.sv
// CPU-facing SRAM responder: clears memory after reset, then serves CPU accesses with loader fill.
module cpu_sram_responder
  import mycpu_head::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int          AW        = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sram_en,
  input  logic [3:0]    sram_wen,
  input  logic [31:0]   sram_addr,
  input  logic [31:0]   sram_wdata,
  output logic [31:0]   sram_rdata,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_index,
  input  logic [31:0]   ld_data,
  output logic          busy,
  output logic [15:0]   oor_cnt
);

  resp_state_t   state, state_next;
  logic [AW-1:0] clr_idx;
  logic          in_range;
  logic [AW-1:0] cpu_idx;
  logic          addr_lsb_unused;

  logic          bank_cs;
  logic [3:0]    bank_wbe;
  logic [AW-1:0] bank_addr;
  logic [31:0]   bank_wdata;
  logic          bank_rd_en;
  logic          bank_rd_clr;
  logic          oor_hit;

  assign in_range        = (sram_addr[31:AW+2] == ADDR_BASE[31:AW+2]);
  assign cpu_idx         = sram_addr[AW+1:2];
  assign addr_lsb_unused = ^sram_addr[1:0];
  assign busy            = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset)                 clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // CPU wins the single bank port; the loader only gets idle cycles.
  always_comb begin
    state_next  = state;
    bank_cs     = 1'b0;
    bank_wbe    = 4'h0;
    bank_addr   = cpu_idx;
    bank_wdata  = sram_wdata;
    bank_rd_en  = 1'b0;
    bank_rd_clr = 1'b0;
    oor_hit     = 1'b0;
    ld_ready    = 1'b0;
    case (state)
      ST_CLEAR: begin
        bank_cs     = 1'b1;
        bank_wbe    = 4'hF;
        bank_addr   = clr_idx;
        bank_wdata  = '0;
        bank_rd_clr = sram_en;
        if (clr_idx == {AW{1'b1}}) state_next = ST_RUN;
      end
      ST_RUN: begin
        ld_ready = !sram_en;
        if (sram_en) begin
          if (in_range) begin
            bank_cs    = 1'b1;
            bank_wbe   = sram_wen;
            bank_rd_en = 1'b1;
          end else begin
            bank_rd_clr = 1'b1;
            oor_hit     = 1'b1;
          end
        end else if (ld_valid) begin
          bank_cs    = 1'b1;
          bank_wbe   = 4'hF;
          bank_addr  = ld_index;
          bank_wdata = ld_data;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
    if (reset) bank_cs = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)                             oor_cnt <= '0;
    else if (oor_hit && oor_cnt != 16'hFFFF) oor_cnt <= oor_cnt + 16'd1;
  end

  sram_bank #(.AW(AW)) u_bank (
    .clk    (clk),
    .reset  (reset),
    .cs     (bank_cs),
    .wbe    (bank_wbe),
    .addr   (bank_addr),
    .wdata  (bank_wdata),
    .rd_en  (bank_rd_en),
    .rd_clr (bank_rd_clr),
    .rdata  (sram_rdata)
  );

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Self-checking bench for cpu_sram_responder: vector table plus scoreboard-backed reference model.
module tb_cpu_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_wdata = '0;
  logic [31:0] sram_rdata;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [9:0]  ld_index = '0;
  logic [31:0] ld_data = '0;
  logic        busy;
  logic [15:0] oor_cnt;

  always #5 clk = ~clk;

  cpu_sram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_index   (ld_index),
    .ld_data    (ld_data),
    .busy       (busy),
    .oor_cnt    (oor_cnt)
  );

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ldv;
    logic [9:0]  ldi;
    logic [31:0] ldd;
    logic [31:0] exp_rdata;
    logic [15:0] exp_oor;
  } vec_t;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] model_mem [1024];
  logic [31:0] model_rdata;
  logic [15:0] model_oor;
  int          clear_left;
  logic [31:0] sb_q [$];
  vec_t        vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    if (sb_q.size() > 0) begin
      model_rdata = sb_q.pop_front();
      check("rdata", sram_rdata, model_rdata);
    end else begin
      check("rdata_hold", sram_rdata, model_rdata);
    end
    check("oor_cnt", {16'h0, oor_cnt}, {16'h0, model_oor});
    check("busy", {31'h0, busy}, {31'h0, clear_left != 0});
  endtask

  // One clock of stimulus; the reference model predicts the next-cycle outputs.
  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ldv, input logic [9:0] ldi,
                               input logic [31:0] ldd);
    logic       busy_m;
    logic [9:0] idx;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    ld_valid   = ldv;
    ld_index   = ldi;
    ld_data    = ldd;
    #1;
    busy_m = (clear_left != 0);
    check("ld_ready", {31'h0, ld_ready}, {31'h0, !busy_m && !en});
    idx = addr[11:2];
    if (en) begin
      if (busy_m) begin
        sb_q.push_back(32'h0);
      end else if (addr[31:12] == 20'h1C000) begin
        sb_q.push_back(model_mem[idx]);
        for (int b = 0; b < 4; b++) begin
          if (wen[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        sb_q.push_back(32'h0);
        if (model_oor != 16'hFFFF) model_oor = model_oor + 16'd1;
      end
    end else if (ldv && !busy_m) begin
      model_mem[ldi] = ldd;
    end
    @(posedge clk);
    #1;
    if (clear_left > 0) clear_left--;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 10'h0, 32'h0);
  endtask

  // A write and a loader beat ride along with reset; both must be discarded.
  task automatic doReset();
    reset      = 1'b1;
    sram_en    = 1'b1;
    sram_wen   = 4'hF;
    sram_addr  = 32'h1C000000;
    sram_wdata = 32'hFFFFFFFF;
    ld_valid   = 1'b1;
    ld_index   = 10'd0;
    ld_data    = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    sram_en  = 1'b0;
    ld_valid = 1'b0;
    clear_left  = 1024;
    model_rdata = 32'h0;
    model_oor   = 16'h0;
    sb_q.delete();
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    checkOutput();
  endtask

  task automatic countBusy(input string name, input int poke_at);
    int n;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      if (busy !== 1'b1) break;
      n++;
      if (k == poke_at) applyStimulus(1'b1, 4'h0, 32'h00000000, 32'h0, 1'b1, 10'd7, 32'h77777777);
      else              idle(1);
    end
    check(name, n, 32'd1024);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 32'h1C000000, 32'h0,        1'b0, 10'd0, 32'h0,        32'h00000000, 16'd0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 10'd0, 32'h02800C0C, 32'h00000000, 16'd0};
    vecs[2]  = '{1'b1, 4'h0, 32'h1C000000, 32'h0,        1'b0, 10'd0, 32'h0,        32'h02800C0C, 16'd0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 10'd1, 32'h11223344, 32'h02800C0C, 16'd0};
    vecs[4]  = '{1'b1, 4'h3, 32'h1C000004, 32'hAABBCCDD, 1'b0, 10'd0, 32'h0,        32'h11223344, 16'd0};
    vecs[5]  = '{1'b1, 4'h0, 32'h1C000004, 32'h0,        1'b0, 10'd0, 32'h0,        32'h1122CCDD, 16'd0};
    vecs[6]  = '{1'b1, 4'h0, 32'h1BFFFFFC, 32'h0,        1'b0, 10'd0, 32'h0,        32'h00000000, 16'd1};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 10'd0, 32'h0,        32'h00000000, 16'd1};
    vecs[8]  = '{1'b1, 4'h0, 32'h1C000FFC, 32'h0,        1'b0, 10'd0, 32'h0,        32'h00000000, 16'd1};
    vecs[9]  = '{1'b1, 4'hF, 32'h1C000FFC, 32'hDEADBEEF, 1'b0, 10'd0, 32'h0,        32'h00000000, 16'd1};
    vecs[10] = '{1'b1, 4'h0, 32'h1C000FFC, 32'h0,        1'b0, 10'd0, 32'h0,        32'hDEADBEEF, 16'd1};
    vecs[11] = '{1'b1, 4'h0, 32'h1C001000, 32'h0,        1'b0, 10'd0, 32'h0,        32'h00000000, 16'd2};
    vecs[12] = '{1'b1, 4'h0, 32'h1C000003, 32'h0,        1'b0, 10'd0, 32'h0,        32'h02800C0C, 16'd2};
    vecs[13] = '{1'b1, 4'h8, 32'h1C000000, 32'h55000000, 1'b0, 10'd0, 32'h0,        32'h02800C0C, 16'd2};
    vecs[14] = '{1'b1, 4'h0, 32'h1C000000, 32'h0,        1'b0, 10'd0, 32'h0,        32'h55800C0C, 16'd2};
    vecs[15] = '{1'b1, 4'hF, 32'h1BFFFFFC, 32'h12345678, 1'b0, 10'd0, 32'h0,        32'h00000000, 16'd3};
    vecs[16] = '{1'b1, 4'h0, 32'h1C000000, 32'h0,        1'b0, 10'd0, 32'h0,        32'h55800C0C, 16'd3};
    vecs[17] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 10'd2, 32'hCAFEF00D, 32'h55800C0C, 16'd3};
    vecs[18] = '{1'b1, 4'h0, 32'h1C000008, 32'h0,        1'b0, 10'd0, 32'h0,        32'hCAFEF00D, 16'd3};

    doReset();
    countBusy("busy_cycles_after_reset", 10);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                    vecs[i].ldv, vecs[i].ldi, vecs[i].ldd);
      check($sformatf("vec%0d_rdata", i), sram_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_oor", i), {16'h0, oor_cnt}, {16'h0, vecs[i].exp_oor});
    end

    // Loader offer held against three CPU cycles, accepted once the CPU goes idle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'h0, 32'h1C000004, 32'h0, 1'b1, 10'd3, 32'h12345678);
      check("stall_rdata", sram_rdata, 32'h1122CCDD);
    end
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 10'd3, 32'h12345678);
    applyStimulus(1'b1, 4'h0, 32'h1C00000C, 32'h0, 1'b0, 10'd0, 32'h0);
    check("stalled_beat_landed", sram_rdata, 32'h12345678);

    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 10'd5, 32'hA5A5A5A5);
    applyStimulus(1'b1, 4'h0, 32'h1C000014, 32'h0, 1'b0, 10'd0, 32'h0);
    check("pre_reset_load", sram_rdata, 32'hA5A5A5A5);

    doReset();
    idle(500);
    doReset();
    countBusy("busy_cycles_after_midclear_reset", -1);
    applyStimulus(1'b1, 4'h0, 32'h1C000014, 32'h0, 1'b0, 10'd0, 32'h0);
    check("cleared_word5", sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h1C00000C, 32'h0, 1'b0, 10'd0, 32'h0);
    check("cleared_word3", sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h1C000FFC, 32'h0, 1'b0, 10'd0, 32'h0);
    check("cleared_word1023", sram_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
